// File: rtl/iterative_shift_unit_pkg.sv
// Shared types and constants for the iterative shift unit.
package shift_unit_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Operand/result handshake bundle between ID/EX registers, the shifter and the EX result mux.
interface iterative_shift_unit_if #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iterative_shift_unit_step.sv
// One iteration of the shifter: conditional shift of acc by 2^step, left or right.
module linear_shift_right #(
    parameter int WIDTH = 64,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    assign dout = {{SHIFT{1'b0}}, din[WIDTH-1:SHIFT]};
endmodule

module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [SHAMT_W-1:0] step,
    input  logic               dir,
    input  logic               en,
    output logic [WIDTH-1:0]   next_acc
);
    logic [WIDTH-1:0]              rev_in, src, sel, rev_sel;
    logic [SHAMT_W-1:0][WIDTH-1:0] sh;

    // Left shifts reuse the right shifters by mirroring the word in and out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev_in[i]  = acc[WIDTH-1-i];
        assign rev_sel[i] = sel[WIDTH-1-i];
    end

    assign src = (dir == DIR_RIGHT) ? acc : rev_in;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_sh
        linear_shift_right #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_lsr (
            .din  (src),
            .dout (sh[k])
        );
    end

    always_comb begin
        sel = src;
        for (int k = 0; k < SHAMT_W; k++)
            if (step == SHAMT_W'(k)) sel = sh[k];
    end

    assign next_acc = !en ? acc : ((dir == DIR_RIGHT) ? sel : rev_sel);
endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle LSL/LSR: one shamt bit per cycle, LSB first, fixed latency SHAMT_W+1.
module iterative_shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    iterative_shift_unit_if.slave bus
);
    shift_state_t       state_q, state_d;
    logic [WIDTH-1:0]   acc, next_acc;
    logic [SHAMT_W-1:0] shamt_q, step;
    logic               dir_q, bit_en, accept;

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = (state_q == S_DONE) ? acc : '0;

    always_comb begin
        bit_en = 1'b0;
        for (int k = 0; k < SHAMT_W; k++)
            if (step == SHAMT_W'(k)) bit_en = shamt_q[k];
    end

    shift_step #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_step (
        .acc      (acc),
        .step     (step),
        .dir      (dir_q),
        .en       (bit_en),
        .next_acc (next_acc)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.in_valid && !flush) begin
                state_d = S_SHIFT;
                accept  = 1'b1;
            end
            S_SHIFT: if (step == SHAMT_W'(SHAMT_W - 1)) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flush wins over accept and over the output handshake; acc is left alone.
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc     <= '0;
            shamt_q <= '0;
            dir_q   <= 1'b0;
            step    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc     <= bus.in_data;
                shamt_q <= bus.in_shamt;
                dir_q   <= bus.in_dir;
                step    <= '0;
            end else if (state_q == S_SHIFT && !flush) begin
                acc  <= next_acc;
                step <= step + SHAMT_W'(1);
            end
        end
    end
endmodule
